// File: rtl/mac_acr_file_pkg.sv
// Shared constants for the MAC accumulator register file: geometry, RF access-part encodings
// and mac_flags_o bit positions.
package mac_acr_file_pkg;

    localparam int unsigned NumAcr = 4;
    localparam int unsigned AcrW   = 40;
    localparam int unsigned RfW    = 16;
    localparam int unsigned SelW   = 2;

    // Read parts use RNDSAT for 2'b11, write parts use HILOAD for the same code.
    localparam logic [1:0] ACR_PART_LOW    = 2'b00;
    localparam logic [1:0] ACR_PART_HIGH   = 2'b01;
    localparam logic [1:0] ACR_PART_GUARD  = 2'b10;
    localparam logic [1:0] ACR_PART_RNDSAT = 2'b11;
    localparam logic [1:0] ACR_PART_HILOAD = 2'b11;

    localparam int unsigned FlagZ = 3;
    localparam int unsigned FlagN = 2;
    localparam int unsigned FlagV = 1;
    localparam int unsigned FlagS = 0;

endpackage

// File: rtl/acr_rnd_sat16.sv
// Combinational round-and-saturate: rounds acc_i[39:16] on bit 15 and clamps the result into
// the signed 16-bit range.
module acr_rnd_sat16
    import mac_acr_file_pkg::*;
(
    input  logic [AcrW-1:0] acc_i,
    output logic [RfW-1:0]  data_o,
    output logic            sat_o
);

    logic signed [24:0] rnd;

    always_comb begin
        // 25 bits hold the 24-bit high part plus the round carry without overflow.
        rnd    = $signed({acc_i[39], acc_i[39:16]}) + $signed({24'd0, acc_i[15]});
        data_o = rnd[15:0];
        sat_o  = 1'b0;
        if (rnd > 25'sd32767) begin
            data_o = 16'h7FFF;
            sat_o  = 1'b1;
        end else if (rnd < -25'sd32768) begin
            data_o = 16'h8000;
            sat_o  = 1'b1;
        end
    end

endmodule

// File: rtl/mac_acr_file.sv
// Accumulator register bank between the MAC datapath and the 16-bit register file, with
// partial RF access, registered round+sat readout, sticky overflow and last-result flags.
module mac_acr_file
    import mac_acr_file_pkg::*;
(
    input  logic              clk_i,
    input  logic              reset_i,
    input  logic [SelW-1:0]   acr_rda_sel_i,
    input  logic [SelW-1:0]   acr_rdb_sel_i,
    output logic [AcrW-1:0]   mac_operanda_o,
    output logic [AcrW-1:0]   mac_operandb_o,
    input  logic              acr_we_i,
    input  logic [SelW-1:0]   acr_wsel_i,
    input  logic [AcrW-1:0]   mac_result_i,
    input  logic              sat_flag_i,
    input  logic              scale_overflow_i,
    input  logic              add_pos_overflow_i,
    input  logic              add_neg_overflow_i,
    input  logic              rf_wr_en_i,
    input  logic [SelW-1:0]   rf_wr_sel_i,
    input  logic [1:0]        rf_wr_part_i,
    input  logic [RfW-1:0]    rf_wr_data_i,
    input  logic              rf_rd_req_i,
    input  logic [SelW-1:0]   rf_rd_sel_i,
    input  logic [1:0]        rf_rd_part_i,
    output logic [RfW-1:0]    rf_rd_data_o,
    output logic              rf_rd_valid_o,
    output logic              rf_rd_sat_o,
    output logic [NumAcr-1:0] acr_ovf_o,
    input  logic              flag_clr_i,
    output logic [3:0]        mac_flags_o,
    output logic              wr_conflict_o
);

    logic [AcrW-1:0]   acr_q [NumAcr];
    logic [AcrW-1:0]   acr_d [NumAcr];
    logic [NumAcr-1:0] ovf_q, ovf_d;
    logic [3:0]        flags_q, flags_d;
    logic [RfW-1:0]    rd_data_q, rd_data_d;
    logic              rd_valid_q, rd_sat_q, rd_sat_d;
    logic              conflict, mac_status;
    logic [AcrW-1:0]   rd_src;
    logic [RfW-1:0]    rnd_data;
    logic              rnd_sat;

    assign mac_operanda_o = acr_q[acr_rda_sel_i];
    assign mac_operandb_o = acr_q[acr_rdb_sel_i];

    assign conflict   = acr_we_i && rf_wr_en_i && (acr_wsel_i == rf_wr_sel_i);
    assign mac_status = sat_flag_i | scale_overflow_i | add_pos_overflow_i | add_neg_overflow_i;

    // Held low during reset so the pulse never escapes while the bank is being cleared.
    assign wr_conflict_o = conflict && reset_i;

    always_comb begin
        acr_d = acr_q;
        if (rf_wr_en_i && !conflict) begin
            case (rf_wr_part_i)
                ACR_PART_LOW:    acr_d[rf_wr_sel_i][15:0]  = rf_wr_data_i;
                ACR_PART_HIGH:   acr_d[rf_wr_sel_i][31:16] = rf_wr_data_i;
                ACR_PART_GUARD:  acr_d[rf_wr_sel_i][39:32] = rf_wr_data_i[7:0];
                ACR_PART_HILOAD: acr_d[rf_wr_sel_i] = {{8{rf_wr_data_i[15]}}, rf_wr_data_i, 16'h0};
            endcase
        end
        if (acr_we_i) begin
            acr_d[acr_wsel_i] = mac_result_i;
        end
    end

    always_comb begin
        ovf_d   = flag_clr_i ? '0 : ovf_q;
        flags_d = flags_q;
        if (acr_we_i) begin
            if (mac_status) begin
                ovf_d[acr_wsel_i] = 1'b1;
            end
            flags_d[FlagZ] = (mac_result_i == '0);
            flags_d[FlagN] = mac_result_i[AcrW-1];
            flags_d[FlagV] = add_pos_overflow_i | add_neg_overflow_i;
            flags_d[FlagS] = sat_flag_i;
        end
    end

    assign rd_src = acr_q[rf_rd_sel_i];

    acr_rnd_sat16 u_rnd_sat (
        .acc_i  (rd_src),
        .data_o (rnd_data),
        .sat_o  (rnd_sat)
    );

    always_comb begin
        rd_data_d = rd_data_q;
        rd_sat_d  = 1'b0;
        if (rf_rd_req_i) begin
            case (rf_rd_part_i)
                ACR_PART_LOW:    rd_data_d = rd_src[15:0];
                ACR_PART_HIGH:   rd_data_d = rd_src[31:16];
                ACR_PART_GUARD:  rd_data_d = {{8{rd_src[39]}}, rd_src[39:32]};
                ACR_PART_RNDSAT: begin
                    rd_data_d = rnd_data;
                    rd_sat_d  = rnd_sat;
                end
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            for (int i = 0; i < NumAcr; i++) begin
                acr_q[i] <= '0;
            end
            ovf_q      <= '0;
            flags_q    <= '0;
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
            rd_sat_q   <= 1'b0;
        end else begin
            acr_q      <= acr_d;
            ovf_q      <= ovf_d;
            flags_q    <= flags_d;
            rd_data_q  <= rd_data_d;
            rd_valid_q <= rf_rd_req_i;
            rd_sat_q   <= rd_sat_d;
        end
    end

    assign rf_rd_data_o  = rd_data_q;
    assign rf_rd_valid_o = rd_valid_q;
    assign rf_rd_sat_o   = rd_sat_q;
    assign acr_ovf_o     = ovf_q;
    assign mac_flags_o   = flags_q;

endmodule

// File: tb/tb_mac_acr_file.sv
// Bench for mac_acr_file: directed scenarios with literal expectations, then random traffic
// checked every cycle against an arithmetic model of the accumulator bank.
module tb_mac_acr_file;

    logic        clk = 1'b0;
    logic        reset_i;
    logic [1:0]  acr_rda_sel_i, acr_rdb_sel_i, acr_wsel_i;
    logic [39:0] mac_operanda_o, mac_operandb_o, mac_result_i;
    logic        acr_we_i, sat_flag_i, scale_overflow_i, add_pos_overflow_i, add_neg_overflow_i;
    logic        rf_wr_en_i, rf_rd_req_i, flag_clr_i;
    logic [1:0]  rf_wr_sel_i, rf_wr_part_i, rf_rd_sel_i, rf_rd_part_i;
    logic [15:0] rf_wr_data_i, rf_rd_data_o;
    logic        rf_rd_valid_o, rf_rd_sat_o, wr_conflict_o;
    logic [3:0]  acr_ovf_o, mac_flags_o;

    int passed = 0;
    int total  = 0;

    always #5 clk = ~clk;

    mac_acr_file dut (
        .clk_i              (clk),
        .reset_i            (reset_i),
        .acr_rda_sel_i      (acr_rda_sel_i),
        .acr_rdb_sel_i      (acr_rdb_sel_i),
        .mac_operanda_o     (mac_operanda_o),
        .mac_operandb_o     (mac_operandb_o),
        .acr_we_i           (acr_we_i),
        .acr_wsel_i         (acr_wsel_i),
        .mac_result_i       (mac_result_i),
        .sat_flag_i         (sat_flag_i),
        .scale_overflow_i   (scale_overflow_i),
        .add_pos_overflow_i (add_pos_overflow_i),
        .add_neg_overflow_i (add_neg_overflow_i),
        .rf_wr_en_i         (rf_wr_en_i),
        .rf_wr_sel_i        (rf_wr_sel_i),
        .rf_wr_part_i       (rf_wr_part_i),
        .rf_wr_data_i       (rf_wr_data_i),
        .rf_rd_req_i        (rf_rd_req_i),
        .rf_rd_sel_i        (rf_rd_sel_i),
        .rf_rd_part_i       (rf_rd_part_i),
        .rf_rd_data_o       (rf_rd_data_o),
        .rf_rd_valid_o      (rf_rd_valid_o),
        .rf_rd_sat_o        (rf_rd_sat_o),
        .acr_ovf_o          (acr_ovf_o),
        .flag_clr_i         (flag_clr_i),
        .mac_flags_o        (mac_flags_o),
        .wr_conflict_o      (wr_conflict_o)
    );

    task automatic check(input string name, input logic [39:0] act, input logic [39:0] exp);
        total++;
        if (act !== exp) $display("FAIL %s: got %h, expected %h", name, act, exp);
        else passed++;
    endtask

    // ---------------- behavioural model ----------------
    logic [39:0] m_acr [4];
    logic [3:0]  m_ovf, m_flags;
    logic [15:0] m_rd_data;
    logic        m_rd_valid, m_rd_sat;

    // Round half-up of the signed 40-bit value at 2^16, then clamp to int16.
    function automatic logic [16:0] rnd_sat(input logic [39:0] a);
        longint s, r;
        s = longint'($signed(a));
        r = (s + 32768) >>> 16;
        if (r > 32767) return {1'b1, 16'h7FFF};
        if (r < -32768) return {1'b1, 16'h8000};
        return {1'b0, r[15:0]};
    endfunction

    always @(posedge clk or negedge reset_i) begin
        if (!reset_i) begin
            for (int i = 0; i < 4; i++) m_acr[i] = '0;
            m_ovf = '0; m_flags = '0; m_rd_data = '0; m_rd_valid = 0; m_rd_sat = 0;
        end else begin
            logic [39:0] a;
            logic [16:0] rs;
            logic        clash;
            a = m_acr[rf_rd_sel_i];
            m_rd_valid = rf_rd_req_i;
            m_rd_sat   = 1'b0;
            if (rf_rd_req_i) begin
                case (rf_rd_part_i)
                    2'd0: m_rd_data = a[15:0];
                    2'd1: m_rd_data = a[31:16];
                    2'd2: m_rd_data = 16'(longint'($signed(a[39:32])));
                    default: begin
                        rs = rnd_sat(a);
                        m_rd_data = rs[15:0];
                        m_rd_sat  = rs[16];
                    end
                endcase
            end
            clash = acr_we_i && rf_wr_en_i && acr_wsel_i == rf_wr_sel_i;
            if (rf_wr_en_i && !clash) begin
                a = m_acr[rf_wr_sel_i];
                case (rf_wr_part_i)
                    2'd0: a = (a & ~40'hFFFF) | 40'(rf_wr_data_i);
                    2'd1: a = (a & ~40'hFFFF_0000) | (40'(rf_wr_data_i) << 16);
                    2'd2: a = (a & 40'h00_FFFF_FFFF) | (40'(rf_wr_data_i[7:0]) << 32);
                    default: a = 40'(longint'($signed(rf_wr_data_i)) * 65536);
                endcase
                m_acr[rf_wr_sel_i] = a;
            end
            if (flag_clr_i) m_ovf = '0;
            if (acr_we_i) begin
                m_acr[acr_wsel_i] = mac_result_i;
                if (sat_flag_i || scale_overflow_i || add_pos_overflow_i || add_neg_overflow_i)
                    m_ovf[acr_wsel_i] = 1'b1;
                m_flags = {mac_result_i == 0, mac_result_i[39],
                           add_pos_overflow_i || add_neg_overflow_i, sat_flag_i};
            end
        end
    end

    // Per-cycle comparison of every output against the model.
    always @(negedge clk) begin
        if (reset_i) begin
            check("operand_a", mac_operanda_o, m_acr[acr_rda_sel_i]);
            check("operand_b", mac_operandb_o, m_acr[acr_rdb_sel_i]);
            check("rd_valid", 40'(rf_rd_valid_o), 40'(m_rd_valid));
            check("rd_data", 40'(rf_rd_data_o), 40'(m_rd_data));
            check("rd_sat", 40'(rf_rd_sat_o), 40'(m_rd_sat));
            check("acr_ovf", 40'(acr_ovf_o), 40'(m_ovf));
            check("mac_flags", 40'(mac_flags_o), 40'(m_flags));
            check("wr_conflict", 40'(wr_conflict_o),
                  40'(acr_we_i && rf_wr_en_i && acr_wsel_i == rf_wr_sel_i));
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        acr_we_i = 0; sat_flag_i = 0; scale_overflow_i = 0; add_pos_overflow_i = 0;
        add_neg_overflow_i = 0; rf_wr_en_i = 0; rf_rd_req_i = 0; flag_clr_i = 0;
    endtask

    task automatic mac_wr(input logic [1:0] sel, input logic [39:0] d);
        acr_we_i = 1; acr_wsel_i = sel; mac_result_i = d;
    endtask

    task automatic rf_wr(input logic [1:0] sel, input logic [1:0] part, input logic [15:0] d);
        rf_wr_en_i = 1; rf_wr_sel_i = sel; rf_wr_part_i = part; rf_wr_data_i = d;
    endtask

    task automatic rf_rd(input logic [1:0] sel, input logic [1:0] part);
        rf_rd_req_i = 1; rf_rd_sel_i = sel; rf_rd_part_i = part;
    endtask

    task automatic rnd_round(input logic [39:0] v, input logic [15:0] exp_d, input logic exp_s);
        mac_wr(0, v); tick(); idle();
        rf_rd(0, 2'b11); tick(); idle();
        check("rnd_valid", 40'(rf_rd_valid_o), 40'd1);
        check("rnd_data", 40'(rf_rd_data_o), 40'(exp_d));
        check("rnd_sat", 40'(rf_rd_sat_o), 40'(exp_s));
    endtask

    initial begin
        idle();
        acr_rda_sel_i = 0; acr_rdb_sel_i = 0; acr_wsel_i = 0; mac_result_i = 0;
        rf_wr_sel_i = 0; rf_wr_part_i = 0; rf_wr_data_i = 0; rf_rd_sel_i = 0; rf_rd_part_i = 0;
        reset_i = 0;
        tick(); tick();
        reset_i = 1;
        check("reset_data", 40'(rf_rd_data_o), 40'd0);
        check("reset_ovf_flags", {32'd0, acr_ovf_o, mac_flags_o}, 40'd0);

        // Asynchronous reset between edges.
        mac_wr(1, 40'h00_1234_5678); tick(); idle();
        acr_rda_sel_i = 1; #1;
        check("pre_reset_acr1", mac_operanda_o, 40'h00_1234_5678);
        reset_i = 0; #1;
        check("async_reset_acr1", mac_operanda_o, 40'd0);
        check("async_reset_outs", {35'd0, rf_rd_valid_o, rf_rd_sat_o, wr_conflict_o,
                                   |acr_ovf_o, |mac_flags_o}, 40'd0);
        tick(); reset_i = 1;

        // Collision: MAC wins.
        mac_wr(2, 40'h7F_0000_0000); rf_wr(2, 2'b11, 16'h1111); #1;
        check("conflict_pulse", 40'(wr_conflict_o), 40'd1);
        tick(); idle();
        acr_rdb_sel_i = 2; #1;
        check("conflict_acr2", mac_operandb_o, 40'h7F_0000_0000);
        check("conflict_clear", 40'(wr_conflict_o), 40'd0);

        rnd_round(40'h00_1234_8000, 16'h1235, 1'b0);
        check("rd_hold_valid_next", 40'(rf_rd_valid_o), 40'd1);
        tick();
        check("rd_valid_drop", 40'(rf_rd_valid_o), 40'd0);
        check("rd_data_hold", 40'(rf_rd_data_o), 40'h1235);
        rnd_round(40'h00_7FFF_8000, 16'h7FFF, 1'b1);
        rnd_round(40'hFF_7FFF_0000, 16'h8000, 1'b1);

        // Sticky flags.
        mac_wr(3, 40'd1); add_pos_overflow_i = 1; tick(); idle();
        check("ovf3_set", 40'(acr_ovf_o[3]), 40'd1);
        check("flags_v", 40'(mac_flags_o), 40'b0010);
        mac_wr(3, 40'd5); scale_overflow_i = 1; flag_clr_i = 1; tick(); idle();
        check("ovf3_set_beats_clr", 40'(acr_ovf_o[3]), 40'd1);
        flag_clr_i = 1; tick(); idle();
        check("ovf_cleared", 40'(acr_ovf_o), 40'd0);

        // Partial writes and read ordering.
        acr_rda_sel_i = 1;
        rf_wr(1, 2'b11, 16'h8001); tick(); idle();
        check("hiload_acr1", mac_operanda_o, 40'hFF_8001_0000);
        rf_wr(1, 2'b10, 16'h0012); rf_rd(1, 2'b10); tick(); idle();
        check("guard_acr1", mac_operanda_o, 40'h12_8001_0000);
        check("old_guard_read", 40'(rf_rd_data_o), 40'h0000_FFFF);

        // Randomised traffic.
        for (int n = 0; n < 3000; n++) begin
            logic [39:0] v;
            v = {$urandom(), $urandom()};
            case ($urandom_range(0, 4))
                0: v = 40'd0;
                1: v = {8'h00, 16'h7FFF, v[15:0]};
                2: v = {8'hFF, 16'h8000, v[15:0]};
                default: ;
            endcase
            acr_rda_sel_i = 2'($urandom); acr_rdb_sel_i = 2'($urandom);
            acr_we_i = ($urandom_range(0, 2) == 0); acr_wsel_i = 2'($urandom);
            mac_result_i = v;
            sat_flag_i = ($urandom_range(0, 7) == 0);
            scale_overflow_i = ($urandom_range(0, 7) == 0);
            add_pos_overflow_i = ($urandom_range(0, 7) == 0);
            add_neg_overflow_i = ($urandom_range(0, 7) == 0);
            rf_wr_en_i = ($urandom_range(0, 1) == 0); rf_wr_sel_i = 2'($urandom);
            rf_wr_part_i = 2'($urandom); rf_wr_data_i = 16'($urandom);
            rf_rd_req_i = ($urandom_range(0, 2) != 0); rf_rd_sel_i = 2'($urandom);
            rf_rd_part_i = 2'($urandom);
            flag_clr_i = ($urandom_range(0, 9) == 0);
            tick();
        end
        idle();
        tick(); tick();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
